// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port register file.
// The package holds the controller state encoding and the default geometry.
package regfile_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-producer tracker: one bit per architectural register.
// An issue sets the destination bit, a write clears it; when both hit the
// same bit in one cycle the issue wins, since it names a newer producer.
// Bit 0 is hard-wired clear because x0 never has a producer.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int AW   = $clog2(NREG),
    parameter int NWR  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    output logic [NREG-1:0]     pend
);

    logic [NREG-1:0] pend_r;
    logic [NREG-1:0] pend_next_s;
    logic [NREG-1:0] clr_mask_s;
    logic [NREG-1:0] set_mask_s;

    // Build clear/set masks; the set mask is OR-ed last so a new producer wins.
    always_comb begin
        clr_mask_s = '0;
        set_mask_s = '0;
        for (int w = 0; w < NWR; w++) begin
            clr_mask_s[wr_addr[w*AW +: AW]] = clr_mask_s[wr_addr[w*AW +: AW]] | wr_en[w];
        end
        set_mask_s[iss_addr] = iss_en;
        set_mask_s[0]        = 1'b0;
        pend_next_s          = (pend_r & ~clr_mask_s) | set_mask_s;
    end

    // Pending vector register; held clear outside normal operation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_r <= '0;
        end else if (!run) begin
            pend_r <= '0;
        end else begin
            pend_r <= pend_next_s;
        end
    end

    assign pend = pend_r;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with a pending-producer scoreboard.
// After reset the block walks every entry writing zero (INIT), then serves
// reads/writes/issues (RUN). x0 always reads zero and is never written.
// Optional feature macro REGFILE_BYPASS_EN: same-cycle write data is
// forwarded to matching reads, which then report no pending producer.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int XLEN = XLEN_DEF,
    parameter  int NREG = NREG_DEF,
    parameter  int NRD  = 2,
    parameter  int NWR  = 1,
    localparam int AW   = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD-1:0]      rd_valid,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_pend,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    output logic                init_done
);

    state_e            state_r;
    logic [AW-1:0]     cnt_r;
    logic              init_done_r;
    logic [XLEN-1:0]   mem_r [NREG];
    logic              run_s;
    logic [NREG-1:0]   pend_s;

    assign run_s     = (state_r == ST_RUN);
    assign init_done = init_done_r;

    // Controller: clear every entry once, then stay in RUN until reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_INIT;
            cnt_r       <= '0;
            init_done_r <= 1'b0;
        end else begin
            case (state_r)
                ST_INIT: begin
                    if (cnt_r == AW'(NREG - 1)) begin
                        state_r     <= ST_RUN;
                        cnt_r       <= '0;
                        init_done_r <= 1'b1;
                    end else begin
                        cnt_r       <= cnt_r + AW'(1);
                        init_done_r <= 1'b0;
                    end
                end
                ST_RUN: begin
                    state_r     <= ST_RUN;
                    init_done_r <= 1'b1;
                end
                default: begin
                    state_r     <= ST_INIT;
                    cnt_r       <= '0;
                    init_done_r <= 1'b0;
                end
            endcase
        end
    end

    // Storage: zero-fill during INIT, otherwise commit writes; later ports win.
    always_ff @(posedge clk) begin
        if (state_r == ST_INIT) begin
            mem_r[cnt_r] <= '0;
        end else begin
            for (int w = 0; w < NWR; w++) begin
                if (wr_en[w] && (wr_addr[w*AW +: AW] != '0)) begin
                    mem_r[wr_addr[w*AW +: AW]] <= wr_data[w*XLEN +: XLEN];
                end
            end
        end
    end

    regfile_scoreboard #(
        .NREG (NREG),
        .AW   (AW),
        .NWR  (NWR)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .run      (run_s),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .pend     (pend_s)
    );

    // Read ports: zero for x0, disabled ports and while clearing.
    always_comb begin
        rd_data = '0;
        rd_pend = '0;
        for (int p = 0; p < NRD; p++) begin
            if (run_s && rd_valid[p] && (rd_addr[p*AW +: AW] != '0)) begin
                rd_data[p*XLEN +: XLEN] = mem_r[rd_addr[p*AW +: AW]];
                rd_pend[p]              = pend_s[rd_addr[p*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
                // Ascending scan so the highest matching write port wins.
                for (int w = 0; w < NWR; w++) begin
                    if (wr_en[w] && (wr_addr[w*AW +: AW] == rd_addr[p*AW +: AW])) begin
                        rd_data[p*XLEN +: XLEN] = wr_data[w*XLEN +: XLEN];
                        rd_pend[p]              = 1'b0;
                    end else begin
                        rd_data[p*XLEN +: XLEN] = rd_data[p*XLEN +: XLEN];
                        rd_pend[p]              = rd_pend[p];
                    end
                end
`endif
            end else begin
                rd_data[p*XLEN +: XLEN] = '0;
                rd_pend[p]              = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (XLEN=32, NREG=32, NRD=2, NWR=2).
module tb_regfile_mp;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [1:0]  rd_valid;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_pend;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic        init_done;

    regfile_mp #(.XLEN(32), .NREG(32), .NRD(2), .NWR(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .rd_valid  (rd_valid),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_pend   (rd_pend),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .iss_en    (iss_en),
        .iss_addr  (iss_addr),
        .init_done (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  rv;
        logic [4:0]  ra0, ra1;
        logic [1:0]  we;
        logic [4:0]  wa0, wa1;
        logic [31:0] wd0, wd1;
        logic        ie;
        logic [4:0]  ia;
        logic [31:0] ed0, ed1;
        logic [1:0]  ep;
    } vec_t;

    typedef struct {
        logic [31:0] ed0, ed1;
        logic [1:0]  ep;
    } exp_t;

    vec_t tbl[21];
    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(input logic [1:0] rv, input logic [4:0] ra0, input logic [4:0] ra1,
                                input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
                                input logic [4:0] wa1, input logic [31:0] wd1,
                                input logic ie, input logic [4:0] ia,
                                input logic [31:0] ed0, input logic [31:0] ed1, input logic [1:0] ep);
        vec_t v;
        v.rv = rv; v.ra0 = ra0; v.ra1 = ra1;
        v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
        v.ie = ie; v.ia = ia;
        v.ed0 = ed0; v.ed1 = ed1; v.ep = ep;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        rd_valid = 2'b00; rd_addr = '0;
        wr_en = 2'b00; wr_addr = '0; wr_data = '0;
        iss_en = 1'b0; iss_addr = 5'd0;
    endtask

    task automatic read_now(input logic [4:0] a0, input logic [4:0] a1);
        rd_valid = 2'b11;
        rd_addr  = {a1, a0};
    endtask

    // Counts clock edges until init_done rises (bounded).
    task automatic wait_init(output int cycles);
        cycles = 0;
        while (init_done !== 1'b1 && cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    initial begin
        int          cyc;
        exp_t        e;
        logic [31:0] p0, p1;

        idle();
        rst = 1'b0;
        read_now(5'd5, 5'd6);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_init_done", {31'd0, init_done}, 32'd0);
        chk("reset_rd_data", rd_data[31:0], 32'd0);

        // Traffic during INIT must be ignored.
        wr_en = 2'b11; wr_addr = {5'd6, 5'd6}; wr_data = {32'h0000_0BAD, 32'h0000_0BAD};
        iss_en = 1'b1; iss_addr = 5'd6;
        @(negedge clk);
        rst = 1'b1;
        wait_init(cyc);
        idle();
        chk("init_cycles", cyc, 32'd32);
        chk("init_done_high", {31'd0, init_done}, 32'd1);

        tbl[0]  = mk(2'b11, 5'd5, 5'd6, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0, 2'b00);
        tbl[1]  = mk(2'b01, 5'd1, 5'd0, 2'b01, 5'd3, 32'hDEAD_BEEF, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0, 2'b00);
        tbl[2]  = mk(2'b01, 5'd3, 5'd0, 2'b01, 5'd0, 32'h0000_1234, 5'd0, 32'h0, 1'b0, 5'd0, 32'hDEAD_BEEF, 32'h0, 2'b00);
        tbl[3]  = mk(2'b01, 5'd0, 5'd3, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0, 2'b00);
        tbl[4]  = mk(2'b00, 5'd0, 5'd0, 2'b11, 5'd7, 32'h11, 5'd7, 32'h22, 1'b0, 5'd0, 32'h0, 32'h0, 2'b00);
        tbl[5]  = mk(2'b01, 5'd7, 5'd0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h22, 32'h0, 2'b00);
        tbl[6]  = mk(2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h0, 32'h0, 2'b00);
        tbl[7]  = mk(2'b01, 5'd9, 5'd9, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0, 2'b01);
        tbl[8]  = mk(2'b11, 5'd9, 5'd7, 2'b01, 5'd9, 32'h55, 5'd0, 32'h0, 1'b0, 5'd0,
                     BYP ? 32'h55 : 32'h0, 32'h22, BYP ? 2'b00 : 2'b01);
        tbl[9]  = mk(2'b11, 5'd9, 5'd3, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h55, 32'hDEAD_BEEF, 2'b00);
        tbl[10] = mk(2'b00, 5'd0, 5'd0, 2'b10, 5'd0, 32'h0, 5'd9, 32'h66, 1'b1, 5'd9, 32'h0, 32'h0, 2'b00);
        tbl[11] = mk(2'b01, 5'd9, 5'd0, 2'b01, 5'd4, 32'h1111, 5'd0, 32'h0, 1'b1, 5'd4, 32'h66, 32'h0, 2'b01);
        tbl[12] = mk(2'b11, 5'd4, 5'd4, 2'b01, 5'd4, 32'hA5A5, 5'd0, 32'h0, 1'b0, 5'd0,
                     BYP ? 32'hA5A5 : 32'h1111, BYP ? 32'hA5A5 : 32'h1111, BYP ? 2'b00 : 2'b11);
        tbl[13] = mk(2'b01, 5'd4, 5'd0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 32'hA5A5, 32'h0, 2'b00);
        tbl[14] = mk(2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h0, 32'h0, 2'b00);
        tbl[15] = mk(2'b11, 5'd0, 5'd3, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'hDEAD_BEEF, 2'b00);
        tbl[16] = mk(2'b00, 5'd0, 5'd0, 2'b11, 5'd20, 32'hCAFE, 5'd2, 32'h2222_2222, 1'b1, 5'd12, 32'h0, 32'h0, 2'b00);
        tbl[17] = mk(2'b11, 5'd20, 5'd2, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 32'hCAFE, 32'h2222_2222, 2'b00);
        tbl[18] = mk(2'b00, 5'd0, 5'd0, 2'b01, 5'd9, 32'h77, 5'd0, 32'h0, 1'b1, 5'd10, 32'h0, 32'h0, 2'b00);
        tbl[19] = mk(2'b11, 5'd10, 5'd9, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h77, 2'b01);
        tbl[20] = mk(2'b01, 5'd12, 5'd0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0, 2'b01);

        // Table loop: drive after the edge, compare before the next edge.
        for (int i = 0; i < 21; i++) begin
            @(posedge clk);
            #1;
            rd_valid = tbl[i].rv;
            rd_addr  = {tbl[i].ra1, tbl[i].ra0};
            wr_en    = tbl[i].we;
            wr_addr  = {tbl[i].wa1, tbl[i].wa0};
            wr_data  = {tbl[i].wd1, tbl[i].wd0};
            iss_en   = tbl[i].ie;
            iss_addr = tbl[i].ia;
            e.ed0 = tbl[i].ed0; e.ed1 = tbl[i].ed1; e.ep = tbl[i].ep;
            exp_q.push_back(e);
            @(negedge clk);
            e = exp_q.pop_front();
            chk($sformatf("v%0d_rd_data0", i), rd_data[31:0], e.ed0);
            chk($sformatf("v%0d_rd_data1", i), rd_data[63:32], e.ed1);
            chk($sformatf("v%0d_rd_pend", i), {30'd0, rd_pend}, {30'd0, e.ep});
        end
        @(posedge clk);
        #1;
        idle();

        // Asynchronous reset while x12 is pending: outputs drop at once.
        read_now(5'd12, 5'd20);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("async_rst_pend", {30'd0, rd_pend}, 32'd0);
        chk("async_rst_init_done", {31'd0, init_done}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Interrupt INIT after 10 cycles; x20 is still stored but must read 0.
        repeat (10) @(posedge clk);
        #1;
        chk("mid_init_done", {31'd0, init_done}, 32'd0);
        p1 = rd_data[63:32];
        chk("mid_init_rd_gated", p1, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        wait_init(cyc);
        chk("reinit_cycles", cyc, 32'd32);
        #1;
        p0 = rd_data[31:0];
        chk("reinit_pend", {30'd0, rd_pend}, 32'd0);
        chk("reinit_x12", p0, 32'd0);
        chk("reinit_x20", rd_data[63:32], 32'd0);
        read_now(5'd3, 5'd7);
        #1;
        chk("reinit_x3", rd_data[31:0], 32'd0);
        chk("reinit_x7", rd_data[63:32], 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL provide parameter XLEN, default 32, data width.
REQ-002 SHALL provide parameter NREG, default 32, register count, power of two, 4..64; AW = clog2(NREG).
REQ-003 SHALL provide parameter NRD, default 2, read port count, 1..4.
REQ-004 SHALL provide parameter NWR, default 1, write port count, 1..2.
REQ-005 SHALL have one clock and an asynchronous, active-low reset.
REQ-006 Port clk, input, 1: sole clock, rising edge.
REQ-007 Port rst, input, 1: asynchronous, active-low reset.
REQ-008 Port rd_valid, input, NRD: per-port read enable.
REQ-009 Port rd_addr, input, NRD*AW: packed read addresses, port p at [p*AW +: AW].
REQ-010 Port rd_data, output, NRD*XLEN: packed read data.
REQ-011 Port rd_pend, output, NRD: addressed register has an outstanding producer.
REQ-012 Port wr_en, input, NWR: write enables.
REQ-013 Port wr_addr, input, NWR*AW: write addresses.
REQ-014 Port wr_data, input, NWR*XLEN: write data.
REQ-015 Port iss_en, input, 1: issue marks iss_addr pending.
REQ-016 Port iss_addr, input, AW: destination of issuing instruction.
REQ-017 Port init_done, output, 1: clear sequence complete, block accepting traffic.

Function
REQ-018 SHALL implement FSM states INIT and RUN; INIT -> RUN after the last entry is cleared; RUN has no exit except reset.
REQ-019 SHALL, in INIT, write zero to entry cnt each cycle (cnt 0..NREG-1), so INIT lasts exactly NREG cycles after reset release.
REQ-020 SHALL, in INIT, ignore wr_en and iss_en, drive rd_data = 0, rd_pend = 0, and init_done = 0.
REQ-021 SHALL drive rd_data combinationally: 0 if !rd_valid[p] or rd_addr[p] == 0, else the stored entry.
REQ-022 SHALL commit writes on the rising clk edge; writes to address 0 are discarded.
REQ-023 SHALL, on same-cycle writes to one address, keep the data from the highest-index write port.
REQ-024 SHALL keep a NREG-bit pending vector; iss_en sets bit iss_addr, and any wr_en clears bit wr_addr.
REQ-025 SHALL, on same-cycle set and clear of one bit, leave it set (the new producer wins).
REQ-026 SHALL never set pending bit 0; rd_pend[p] = rd_valid[p] & pend[rd_addr[p]].
REQ-027 SHALL treat out-of-range addresses (>= NREG when NREG < 2^AW cannot occur) as impossible by construction; no extra checking.

Reset
REQ-028 SHALL, while rst = 0, asynchronously force state INIT, cnt 0, pending vector 0, and init_done 0.
REQ-029 SHALL, if rst is asserted mid-INIT or mid-RUN, restart the full clear sequence; register contents become don't-care until INIT completes.

Configuration
REQ-030 SHALL support macro REGFILE_BYPASS_EN.
REQ-031 With REGFILE_BYPASS_EN defined, a read matching a same-cycle nonzero write address SHALL return wr_data (highest matching port), and rd_pend SHALL read 0 for that register.
REQ-032 With REGFILE_BYPASS_EN undefined, reads SHALL return the pre-edge stored value and rd_pend SHALL reflect the pre-edge pending bit.

Structure
REQ-033 SHALL place the FSM state enum (INIT, RUN) and default XLEN/NREG constants in package regfile_pkg.
REQ-034 SHALL factor the pending vector and its set/clear priority into sub-module regfile_scoreboard.

Verification
REQ-035 Release reset, poll init_done: init_done SHALL be 0 for exactly 32 cycles and then 1; a read of x5 SHALL return 0x00000000.
REQ-036 Write x3 = 0xDEADBEEF, read x3 next cycle -> 0xDEADBEEF; write x0 = 0x1234, read x0 -> 0.
REQ-037 NWR = 2, both ports write x7 (0x11, 0x22) in the same cycle -> x7 SHALL read 0x22.
REQ-038 Issue x9, then read it -> rd_pend = 1; write x9 = 0x55 -> next cycle rd_pend = 0 and data 0x55; issue and write x9 in the same cycle -> pending SHALL remain 1.
REQ-039 With the macro defined, write x4 = 0xA5A5 while reading x4 in the same cycle -> rd_data = 0xA5A5 and rd_pend = 0; with the macro undefined -> old value.
REQ-040 Assert rst at cycle 10 of INIT, then release: init_done SHALL stay 0 for a fresh 32 cycles and pending SHALL be all zero.
